// File: rtl/div_pkg.sv
// ============================================================================
// Package     : div_pkg
// Description : Shared types and constants for the shift_sub_divider block.
//               The sub-phase type is only used when SHIFT_SUB_COMBINED_EN
//               is undefined (separate SHIFT and SUB cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  // Default operand/result width in bits
  localparam int DIV_WIDTH_DEFAULT = 8;

  // Top-level sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Sub-phase within CALC when shift and trial subtract are split
  typedef enum logic {
    PH_SHIFT = 1'b0,
    PH_SUB   = 1'b1
  } div_phase_e;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_regs.sv
// ============================================================================
// Module      : div_regs
// Description : Datapath registers of the restoring divider: partial
//               remainder A (WIDTH+1), dividend/quotient shifter Q and the
//               latched divisor D. Exposes the trial-compare flag and the
//               next-state quotient/remainder so results can be captured on
//               the same edge as the final iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_regs #(
  parameter int WIDTH    = 8,
  parameter bit COMBINED = 1'b0
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             sub_i,
  input  logic             shsub_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ge_o,
  output logic [WIDTH-1:0] q_next_o,
  output logic [WIDTH-1:0] rem_next_o
);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   d_ext;
  logic             ge_comb;
  logic             ge_sub;

  assign d_ext   = {1'b0, d_q};
  assign a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

  // Combined mode compares the freshly shifted A; split mode compares A,
  // which already holds the shifted value from the preceding SHIFT cycle.
  assign ge_comb = (a_shift >= d_ext);
  assign ge_sub  = (a_q >= d_ext);
  assign ge_o    = COMBINED ? ge_comb : ge_sub;

  // Next-state selection for A/Q/D from the control strobes
  always_comb begin
    a_d = a_q;
    q_d = q_q;
    d_d = d_q;
    if (load_i) begin
      a_d = '0;
      q_d = dividend_i;
      d_d = divisor_i;
    end else if (shsub_i) begin
      a_d = a_shift - d_ext;
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end else if (shift_i) begin
      a_d = a_shift;
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end else if (sub_i) begin
      a_d = a_q - d_ext;
      q_d = {q_q[WIDTH-1:1], 1'b1};
    end
  end

  // Datapath register bank
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_q <= '0;
      q_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      d_q <= d_d;
    end
  end

  assign q_next_o   = q_d;
  assign rem_next_o = a_d[WIDTH-1:0];

endmodule : div_regs

`default_nettype wire

// File: rtl/shift_sub_divider.sv
// ============================================================================
// Module      : shift_sub_divider
// Description : Sequential restoring (shift-and-subtract) unsigned divider
//               with start/busy/done handshake. Holds the FSM, iteration
//               counter and result registers; A/Q/D live in div_regs.
//               Build option SHIFT_SUB_COMBINED_EN: when defined, each CALC
//               cycle shifts and trial-subtracts (WIDTH busy cycles); when
//               undefined, SHIFT and SUB cycles alternate (2*WIDTH cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sub_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
`ifdef SHIFT_SUB_COMBINED_EN
  localparam bit                COMBINED = 1'b1;
`else
  localparam bit                COMBINED = 1'b0;
`endif

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifndef SHIFT_SUB_COMBINED_EN
  div_phase_e       phase_q, phase_d;
`endif

  logic             last_iter;
  logic             div_by_zero;
  logic             ctl_load, ctl_shift, ctl_sub, ctl_shsub;
  logic             ge;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_zero_q;

  assign div_by_zero = (divisor == '0);

  // State, counter and sub-phase registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifndef SHIFT_SUB_COMBINED_EN
      phase_q <= PH_SHIFT;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifndef SHIFT_SUB_COMBINED_EN
      phase_q <= phase_d;
`endif
    end
  end

  // Next-state, counter advance and final-iteration detection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_iter = 1'b0;
`ifndef SHIFT_SUB_COMBINED_EN
    phase_d   = phase_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (div_by_zero) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
            cnt_d   = '0;
`ifndef SHIFT_SUB_COMBINED_EN
            phase_d = PH_SHIFT;
`endif
          end
        end
      end
      ST_CALC: begin
`ifdef SHIFT_SUB_COMBINED_EN
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          last_iter = 1'b1;
          state_d   = ST_DONE;
        end
`else
        if (phase_q == PH_SHIFT) begin
          phase_d = PH_SUB;
        end else begin
          phase_d = PH_SHIFT;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            last_iter = 1'b1;
            state_d   = ST_DONE;
          end
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs and datapath control strobes decoded from state
  always_comb begin
    busy      = (state_q == ST_CALC);
    done      = (state_q == ST_DONE);
    ctl_load  = (state_q == ST_IDLE) && start && !div_by_zero;
`ifdef SHIFT_SUB_COMBINED_EN
    ctl_shsub = (state_q == ST_CALC) && ge;
    ctl_shift = (state_q == ST_CALC) && !ge;
    ctl_sub   = 1'b0;
`else
    ctl_shsub = 1'b0;
    ctl_shift = (state_q == ST_CALC) && (phase_q == PH_SHIFT);
    ctl_sub   = (state_q == ST_CALC) && (phase_q == PH_SUB) && ge;
`endif
  end

  div_regs #(
    .WIDTH    (WIDTH),
    .COMBINED (COMBINED)
  ) u_regs (
    .clk        (clk),
    .n_reset    (n_reset),
    .load_i     (ctl_load),
    .shift_i    (ctl_shift),
    .sub_i      (ctl_sub),
    .shsub_i    (ctl_shsub),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .ge_o       (ge),
    .q_next_o   (q_next),
    .rem_next_o (rem_next)
  );

  // Result registers: captured on the edge that enters DONE, held otherwise
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else if ((state_q == ST_IDLE) && start && div_by_zero) begin
      quotient_q  <= '1;
      remainder_q <= dividend;
      div_zero_q  <= 1'b1;
    end else if (last_iter) begin
      quotient_q  <= q_next;
      remainder_q <= rem_next;
      div_zero_q  <= 1'b0;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule : shift_sub_divider

`default_nettype wire

// File: tb/tb_shift_sub_divider.sv
// ============================================================================
// Module      : tb_shift_sub_divider
// Description : Self-checking bench for shift_sub_divider (WIDTH=8). A
//               scoreboard queue holds expected results pushed when a start
//               is driven; a monitor pops and compares on every done pulse.
//               Latency expectations follow SHIFT_SUB_COMBINED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sub_divider;

  localparam int W = 8;
`ifdef SHIFT_SUB_COMBINED_EN
  localparam int N = W;
`else
  localparam int N = 2 * W;
`endif
  localparam int BOUND = 3 * N + 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Reference model of unsigned division with the divide-by-zero convention
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high %0d consecutive cycles, required 1", 2);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got q=%0d r=%0d dz=%0b, required no done",
                 quotient, remainder, div_zero);
      end else begin
        mon_e = sb.pop_front();
        if ({quotient, remainder, div_zero} !== {mon_e.q, mon_e.r, mon_e.dz}) begin
          errors++;
          $display("FAIL result: got q=%0d r=%0d dz=%0b, required q=%0d r=%0d dz=%0b",
                   quotient, remainder, div_zero, mon_e.q, mon_e.r, mon_e.dz);
        end
      end
    end
    prev_done = done;
  end

  // Drive one start pulse; the edge ending the task is the accepting edge E0
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it);
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    if (expect_it) sb.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count cycles after E0 until done; busy cycles seen before done
  task automatic wait_done(output int lat, output int bcyc, output bit ok);
    lat = 0; bcyc = 0; ok = 1'b0;
    for (int i = 1; i <= BOUND; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; ok = 1'b1;
        break;
      end
      if (busy) bcyc++;
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b dz=%0b q=%0d r=%0d, required all 0",
               busy, done, div_zero, quotient, remainder);
    end
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic check_timing(input string name, input int lat, input int bcyc, input bit ok,
                              input int exp_lat, input int exp_busy);
    checks++;
    if (!ok || lat != exp_lat || bcyc != exp_busy) begin
      errors++;
      $display("FAIL %s_timing: got done_at=%0d busy_cycles=%0d seen=%0b, required done_at=%0d busy_cycles=%0d",
               name, lat, bcyc, ok, exp_lat, exp_busy);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] pa [6] = '{8'd100, 8'd255, 8'd5, 8'd0, 8'd255, 8'd1};
    logic [W-1:0] pb [6] = '{8'd7,   8'd1,   8'd9, 8'd3, 8'd255, 8'd255};
    int lat, bcyc; bit ok;
    for (int i = 0; i < 6; i++) begin
      issue(pa[i], pb[i], 1'b1);
      wait_done(lat, bcyc, ok);
      check_timing("directed", lat, bcyc, ok, N + 1, N);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcyc; bit ok;
    issue(8'd200, 8'd0, 1'b1);
    wait_done(lat, bcyc, ok);
    check_timing("div_zero", lat, bcyc, ok, 1, 0);
    checks++;
    if ({div_zero, quotient, remainder} !== {1'b1, 8'hFF, 8'd200}) begin
      errors++;
      $display("FAIL div_zero_values: got dz=%0b q=%0h r=%0d, required dz=1 q=ff r=200",
               div_zero, quotient, remainder);
    end
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    int extra;
    bit ok = 1'b0;
    issue(8'd50, 8'd5, 1'b1);
    for (int i = 1; i <= BOUND; i++) begin
      @(negedge clk);
      if (i == 3) begin start = 1'b1; dividend = 8'd9; divisor = 8'd3; end
      if (i == 4) start = 1'b0;
      if (done) begin
        lat = i; ok = 1'b1;
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_timing("ignore_start", lat, N, ok, N + 1, N);
    count_dones(BOUND, extra);
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_start_dones: got %0d extra done pulses, required 0", extra);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat, bcyc, extra; bit ok;
    issue(8'd77, 8'd4, 1'b0);
    repeat (3) @(negedge clk);
    n_reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL reset_mid_calc: got busy=%0b done=%0b dz=%0b q=%0d r=%0d, required all 0",
               busy, done, div_zero, quotient, remainder);
    end
    @(negedge clk);
    n_reset = 1'b1;
    count_dones(BOUND, extra);
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL aborted_done: got %0d done pulses, required 0", extra);
    end
    issue(8'd81, 8'd9, 1'b1);
    wait_done(lat, bcyc, ok);
    check_timing("after_reset", lat, bcyc, ok, N + 1, N);
  endtask

  task automatic test_sweep();
    int lat, bcyc; bit ok;
    logic [W-1:0] a, b;
    for (int i = 0; i < 600; i++) begin
      a = W'($urandom_range(0, 255));
      b = (i % 25 == 0) ? '0 : W'($urandom_range(0, 255));
      if (i < 16) begin a = 8'hFF; b = W'(i + 1); end
      issue(a, b, 1'b1);
      wait_done(lat, bcyc, ok);
      if (b == '0) check_timing("sweep_dz", lat, bcyc, ok, 1, 0);
      else         check_timing("sweep", lat, bcyc, ok, N + 1, N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_calc();
    test_sweep();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding results, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_shift_sub_divider

`default_nettype wire
